// File: rtl/mt_pkg.sv
// Shared types and helpers for the multitap topology sequencer.
// Pure declarations: no latency, no flow control.
// Normalisation folds illegal request combinations into one legal topology.
package mt_pkg;

    typedef enum logic [1:0] {
        MT_IDLE       = 2'd0,
        MT_WAIT_QUIET = 2'd1,
        MT_SETTLE     = 2'd2
    } mt_state_e;

    typedef struct packed {
        logic [1:0] tp;
        logic       fw;
    } mt_cfg_t;

    localparam logic [3:0] MT_A_DATA1 = 4'd1;
    localparam logic [3:0] MT_A_DATA2 = 4'd2;
    localparam logic [3:0] MT_A_CTRL1 = 4'd4;
    localparam logic [3:0] MT_A_CTRL2 = 4'd5;

    // 4-Way Play owns both ports; Team Player can only sit on one port.
    function automatic mt_cfg_t mt_normalize(input logic [1:0] tp, input logic fw);
        mt_cfg_t cfg;
        cfg.fw = fw;
        if (fw) begin
            cfg.tp = 2'b00;
        end else if (tp == 2'b11) begin
            cfg.tp = 2'b01;
        end else begin
            cfg.tp = tp;
        end
        return cfg;
    endfunction

    function automatic logic mt_is_port_addr(input logic [3:0] a);
        return (a == MT_A_DATA1) || (a == MT_A_DATA2) ||
               (a == MT_A_CTRL1) || (a == MT_A_CTRL2);
    endfunction

endpackage

// File: rtl/mt_tick_cnt.sv
// CE-gated 16-bit saturating counter with sync clear and hit-on-limit flag.
// hit is combinational on the value being loaded, so a caller can act on the same edge.
// No backpressure; clear has priority over counting.
module mt_tick_cnt #(
    parameter logic [15:0] LIMIT = 16'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic en,
    input  logic clr,
    output logic hit
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en && ce && (cnt_q != 16'hFFFF)) begin
            cnt_nxt = cnt_q + 16'd1;
        end
    end

    assign hit = (cnt_nxt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/multitap_mode_ctrl.sv
// Applies OSD topology requests to the multitap only while the CPU is off the pad ports.
// Latency: QUIET_CYC quiet CE ticks (or TIMEOUT_CYC ticks) to apply, then SETTLE_CYC ticks of masking.
// No backpressure: the latest request always wins until it is applied.
module multitap_mode_ctrl
    import mt_pkg::*;
#(
    parameter logic [15:0] QUIET_CYC   = 16'd2000,
    parameter logic [15:0] TIMEOUT_CYC = 16'd60000,
    parameter logic [15:0] SETTLE_CYC  = 16'd4000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic [1:0] REQ_TP,
    input  logic       REQ_FW,
    input  logic       SEL,
    input  logic [3:0] A,
    output logic [1:0] TEAMPLAYER_EN,
    output logic       FOURWAY_EN,
    output logic       PAD_MASK,
    output logic       BUSY
);

    mt_state_e state_q;
    mt_state_e state_nxt;
    mt_cfg_t   target;
    mt_cfg_t   applied_q;
    logic      load_cfg;
    logic      port_access;
    logic      quiet_hit;
    logic      wait_hit;
    logic      settle_hit;
    logic      pad_mask_q;
    logic      busy_q;

    assign target      = mt_normalize(REQ_TP, REQ_FW);
    assign port_access = SEL && mt_is_port_addr(A);

    // Counters sit at zero outside their own state, so entering a state starts from 0.
    mt_tick_cnt #(.LIMIT(QUIET_CYC)) u_quiet_cnt (
        .clk (CLK),
        .rst (RESET),
        .ce  (CE),
        .en  (state_q == MT_WAIT_QUIET),
        .clr ((state_q != MT_WAIT_QUIET) || port_access),
        .hit (quiet_hit)
    );

    mt_tick_cnt #(.LIMIT(TIMEOUT_CYC)) u_wait_cnt (
        .clk (CLK),
        .rst (RESET),
        .ce  (CE),
        .en  (state_q == MT_WAIT_QUIET),
        .clr (state_q != MT_WAIT_QUIET),
        .hit (wait_hit)
    );

    mt_tick_cnt #(.LIMIT(SETTLE_CYC)) u_settle_cnt (
        .clk (CLK),
        .rst (RESET),
        .ce  (CE),
        .en  (state_q == MT_SETTLE),
        .clr (state_q != MT_SETTLE),
        .hit (settle_hit)
    );

    always_comb begin
        state_nxt = state_q;
        load_cfg  = 1'b0;
        case (state_q)
            MT_IDLE: begin
                if (target != applied_q) begin
                    state_nxt = MT_WAIT_QUIET;
                end
            end
            MT_WAIT_QUIET: begin
                // A reverted request cancels silently, even if a counter just hit.
                if (target == applied_q) begin
                    state_nxt = MT_IDLE;
                end else if (quiet_hit || wait_hit) begin
                    state_nxt = MT_SETTLE;
                    load_cfg  = 1'b1;
                end
            end
            MT_SETTLE: begin
                if (settle_hit) begin
                    state_nxt = MT_IDLE;
                end
            end
            default: begin
                state_nxt = MT_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= MT_IDLE;
            applied_q  <= target;
            pad_mask_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            pad_mask_q <= (state_nxt == MT_SETTLE);
            busy_q     <= (state_nxt != MT_IDLE);
            if (load_cfg) begin
                applied_q <= target;
            end
        end
    end

    assign TEAMPLAYER_EN = applied_q.tp;
    assign FOURWAY_EN    = applied_q.fw;
    assign PAD_MASK      = pad_mask_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_multitap_mode_ctrl.sv
// Bench for multitap_mode_ctrl: reset-normalisation table, timed corner sequences,
// and a randomized run against an event-level reference model.
module tb_multitap_mode_ctrl;

    localparam int Q = 8;
    localparam int T = 40;
    localparam int S = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic [1:0] req_tp = 2'b00;
    logic       req_fw = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] a = 4'd0;
    logic [1:0] tp_en;
    logic       fw_en;
    logic       pad_mask;
    logic       busy;

    int  checks = 0;
    int  errs = 0;
    bit  chk_model = 0;
    bit  pad_seen = 0;

    // Reference model state: what is applied, whether a change is pending,
    // ticks since the last port access, ticks spent pending, masking ticks left.
    logic [2:0] m_app;
    bit         m_pending = 0;
    int         m_quiet = 0;
    int         m_waited = 0;
    int         m_settle_left = 0;

    always #5 clk = ~clk;

    multitap_mode_ctrl #(
        .QUIET_CYC   (16'd8),
        .TIMEOUT_CYC (16'd40),
        .SETTLE_CYC  (16'd5)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .CE            (ce),
        .REQ_TP        (req_tp),
        .REQ_FW        (req_fw),
        .SEL           (sel),
        .A             (a),
        .TEAMPLAYER_EN (tp_en),
        .FOURWAY_EN    (fw_en),
        .PAD_MASK      (pad_mask),
        .BUSY          (busy)
    );

    function automatic logic [2:0] ref_norm(input logic [1:0] tp, input logic fw);
        if (fw) return 3'b001;
        if (tp == 2'b11) return 3'b010;
        return {tp, 1'b0};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [1:0] tp, input logic fw,
                              input bit tick, input bit acc);
        logic [2:0] tgt;
        tgt = ref_norm(tp, fw);
        if (r) begin
            m_app = tgt;
            m_pending = 0;
            m_settle_left = 0;
        end else if (m_settle_left > 0) begin
            if (tick) m_settle_left--;
        end else if (m_pending) begin
            if (tgt == m_app) begin
                m_pending = 0;
            end else begin
                if (acc) m_quiet = 0;
                else if (tick && m_quiet < 65535) m_quiet++;
                if (tick) m_waited++;
                if (m_quiet == Q || m_waited == T) begin
                    m_app = tgt;
                    m_pending = 0;
                    m_settle_left = S;
                end
            end
        end else if (tgt != m_app) begin
            m_pending = 1;
            m_quiet = 0;
            m_waited = 0;
        end
    endtask

    task automatic cyc();
        bit r, tick, acc;
        logic [1:0] tp;
        logic fw;
        logic [4:0] exp_v;
        r = rst; tick = ce; tp = req_tp; fw = req_fw;
        acc = sel && (a == 4'd1 || a == 4'd2 || a == 4'd4 || a == 4'd5);
        @(posedge clk);
        #1;
        model_step(r, tp, fw, tick, acc);
        if (pad_mask) pad_seen = 1;
        if (chk_model) begin
            exp_v = {m_app, (m_settle_left > 0), (m_pending || m_settle_left > 0)};
            check("model {tp,fw,pad,busy}", {tp_en, fw_en, pad_mask, busy}, exp_v);
        end
    endtask

    task automatic do_reset(input logic [1:0] tp, input logic fw);
        rst = 1; req_tp = tp; req_fw = fw; sel = 0; ce = 1;
        cyc();
        rst = 0;
    endtask

    task automatic run_while_busy(output int n);
        n = 0;
        while (busy && n < 500) begin cyc(); n++; end
    endtask

    typedef struct {
        logic [1:0] tp;
        logic       fw;
        logic [1:0] exp_tp;
        logic       exp_fw;
    } norm_vec_t;

    norm_vec_t vecs[8];

    initial begin
        int n;
        vecs[0] = '{2'b00, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 2'b01, 1'b0};
        vecs[2] = '{2'b10, 1'b0, 2'b10, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 2'b01, 1'b0};
        vecs[4] = '{2'b00, 1'b1, 2'b00, 1'b1};
        vecs[5] = '{2'b01, 1'b1, 2'b00, 1'b1};
        vecs[6] = '{2'b10, 1'b1, 2'b00, 1'b1};
        vecs[7] = '{2'b11, 1'b1, 2'b00, 1'b1};

        // Reset loads the normalised request directly.
        for (int i = 0; i < 8; i++) begin
            do_reset(vecs[i].tp, vecs[i].fw);
            check("reset tp", tp_en, vecs[i].exp_tp);
            check("reset fw", fw_en, vecs[i].exp_fw);
            check("reset busy", busy, 0);
            check("reset pad", pad_mask, 0);
        end

        // 4-Way request with a silent bus: 8 quiet ticks, then 5 masked ticks.
        do_reset(2'b00, 1'b0);
        req_fw = 1;
        cyc();
        check("fw busy rise", busy, 1);
        check("fw not yet applied", fw_en, 0);
        n = 0;
        while (!fw_en && n < 100) begin cyc(); n++; end
        check("fw apply delay", n, Q);
        check("fw pad with apply", pad_mask, 1);
        n = 0;
        while (pad_mask && n < 100) begin cyc(); n++; end
        check("fw settle length", n, S);
        check("fw busy after settle", busy, 0);
        check("fw applied", fw_en, 1);

        // Port-1 access every 6 cycles keeps it from going quiet: forced by timeout.
        req_fw = 0; req_tp = 2'b01;
        cyc();
        check("to busy rise", busy, 1);
        n = 0;
        while (tp_en != 2'b01 && n < 200) begin
            sel = (n % 6 == 0); a = 4'd1;
            cyc(); n++;
        end
        sel = 0;
        check("timeout apply delay", n, T);
        check("timeout pad", pad_mask, 1);
        check("timeout fw cleared", fw_en, 0);
        n = 0;
        while (pad_mask && n < 100) begin cyc(); n++; end
        check("timeout settle length", n, S);

        // TP=11 folds to port 1; FW overrides TP.
        do_reset(2'b00, 1'b0);
        req_tp = 2'b11;
        cyc();
        run_while_busy(n);
        check("tp11 applied tp", tp_en, 2'b01);
        req_tp = 2'b10; req_fw = 1;
        cyc();
        run_while_busy(n);
        check("fw+tp10 applied tp", tp_en, 2'b00);
        check("fw+tp10 applied fw", fw_en, 1);

        // Revert during WAIT_QUIET: back to idle, nothing applied, no mask.
        do_reset(2'b00, 1'b0);
        pad_seen = 0;
        req_tp = 2'b10;
        cyc();
        repeat (3) cyc();
        req_tp = 2'b00;
        cyc();
        check("abort busy", busy, 0);
        repeat (20) cyc();
        check("abort tp", tp_en, 2'b00);
        check("abort pad never", pad_seen, 0);

        // Request change during SETTLE is held off, then a second sequence runs.
        do_reset(2'b00, 1'b0);
        req_tp = 2'b10;
        n = 0;
        while (!pad_mask && n < 100) begin cyc(); n++; end
        check("settle1 tp", tp_en, 2'b10);
        req_tp = 2'b01;
        repeat (2) cyc();
        check("settle frozen tp", tp_en, 2'b10);
        n = 0;
        while (pad_mask && n < 100) begin cyc(); n++; end
        check("settle1 end tp", tp_en, 2'b10);
        check("settle1 end busy", busy, 0);
        cyc();
        check("second seq busy", busy, 1);
        n = 0;
        while (!pad_mask && n < 100) begin cyc(); n++; end
        check("second seq delay", n, Q);
        check("second seq tp", tp_en, 2'b01);
        run_while_busy(n);

        // Reset in the middle of SETTLE: no further masking.
        do_reset(2'b00, 1'b0);
        req_tp = 2'b01;
        n = 0;
        while (!pad_mask && n < 100) begin cyc(); n++; end
        repeat (2) cyc();
        rst = 1;
        cyc();
        rst = 0;
        check("mid reset pad", pad_mask, 0);
        check("mid reset busy", busy, 0);
        check("mid reset tp", tp_en, 2'b01);

        // Accesses to non-port registers do not disturb the quiet window.
        do_reset(2'b00, 1'b0);
        req_tp = 2'b10;
        cyc();
        n = 0;
        while (tp_en != 2'b10 && n < 100) begin
            sel = 1; a = (n % 2 == 0) ? 4'd3 : 4'd6;
            cyc(); n++;
        end
        sel = 0;
        check("non-port access delay", n, Q);

        // Randomized traffic with CE gaps, bursty bus access and occasional reset.
        do_reset(2'b00, 1'b0);
        chk_model = 1;
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            dens = (blk % 2 == 0) ? 12 : 2;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    req_tp = 2'($urandom_range(0, 3));
                    req_fw = ($urandom_range(0, 3) == 0);
                end
                ce  = ($urandom_range(0, 3) != 0);
                sel = ($urandom_range(0, dens - 1) == 0);
                a   = 4'($urandom_range(0, 7));
                rst = ($urandom_range(0, 999) == 0);
                cyc();
            end
        end
        rst = 0; sel = 0; ce = 1;
        chk_model = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/multitap_mode_ctrl.md
Name: multitap_mode_ctrl

Overview:
Sequences run-time changes of the controller-port topology: plain pads, Team Player on port 1 or 2, or 4-Way Play. The OSD writes a requested configuration at any time. This block applies it to the multitap datapath only when the game is not mid-protocol on the I/O ports, then holds pad inputs released for a settle window. It sits between the OSD config registers and the multitap's TEAMPLAYER_EN/FOURWAY_EN inputs and pad-input gating.

Parameters:
QUIET_CYC, 16'd2000, CE ticks without port I/O access before a change is allowed.
TIMEOUT_CYC, 16'd60000, CE ticks in WAIT_QUIET after which the change is forced.
SETTLE_CYC, 16'd4000, CE ticks of PAD_MASK after the change is applied.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CE  in  1  I/O clock enable; all counters advance only on CE=1
REQ_TP  in  2  requested Team Player enable: [0] port 1, [1] port 2
REQ_FW  in  1  requested 4-Way Play enable
SEL  in  1  I/O register strobe from the CPU bus
A  in  4  I/O register address [4:1]
TEAMPLAYER_EN  out  2  applied Team Player enable, to the multitap
FOURWAY_EN  out  1  applied 4-Way Play enable, to the multitap
PAD_MASK  out  1  high = the top level forces all P1..P5 buttons released
BUSY  out  1  high whenever state != IDLE

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RESET).
- Normalisation, combinational, applied to every request:
  - REQ_FW=1 gives target {TP=00, FW=1}.
  - Otherwise REQ_TP=11 gives TP=01.
  - Otherwise the target is REQ_TP as given with FW=0.
- Port access: SEL=1 with A in {1,2,4,5}, i.e. data or control register of port 1 or 2. Sampled every CLK, independent of CE.
- Reset:
  - TEAMPLAYER_EN/FOURWAY_EN load the normalised request directly.
  - State=IDLE; PAD_MASK=0, BUSY=0; all counters=0.
- State IDLE:
  - If target != applied, go to WAIT_QUIET next cycle and clear quiet_cnt and wait_cnt.
- State WAIT_QUIET:
  - The target is re-sampled every cycle, so the latest request wins.
  - A port access clears quiet_cnt. Otherwise, on CE, quiet_cnt increments, saturating at 16 bits.
  - On CE, wait_cnt increments.
  - Access and CE in the same cycle: the access wins and quiet_cnt=0.
  - If target == applied again, return to IDLE with no output change and no PAD_MASK.
  - If quiet_cnt == QUIET_CYC, or wait_cnt == TIMEOUT_CYC: the outputs load the target on the next edge, PAD_MASK=1 the same edge, go to SETTLE with settle_cnt=0.
- State SETTLE:
  - PAD_MASK=1; settle_cnt increments on CE.
  - Applied outputs are frozen even if the request changes.
  - At settle_cnt == SETTLE_CYC, PAD_MASK drops and state goes to IDLE next edge.
  - If target != applied at that point, IDLE re-enters WAIT_QUIET on the following cycle.
- Applied outputs change only on the WAIT_QUIET to SETTLE edge or on reset. They are glitch-free registers.
- RESET mid-sequence abandons the sequence and takes reset values above. No PAD_MASK pulse follows.
- CE=0 for a long period: the state is held, except that a port access still clears quiet_cnt.

Decomposition:
- Shared package mt_pkg:
  - state enum {MT_IDLE, MT_WAIT_QUIET, MT_SETTLE};
  - struct mt_cfg_t {logic [1:0] tp; logic fw;};
  - function mt_normalize(tp, fw) returning mt_cfg_t;
  - port-address constants MT_A_DATA1=1, MT_A_DATA2=2, MT_A_CTRL1=4, MT_A_CTRL2=5.
- One sub-module is natural: mt_tick_cnt, a CE-gated 16-bit counter with sync clear, saturation and compare-equal output. It is instantiated three times (quiet, wait, settle).

Test Plan:
- Bench parameters QUIET_CYC=8, TIMEOUT_CYC=40, SETTLE_CYC=5 unless stated.
- Reset with REQ_TP=10, REQ_FW=0 -> TEAMPLAYER_EN=10, FOURWAY_EN=0, BUSY=0 on the first cycle after reset, no PAD_MASK.
- CE=1 every cycle; from applied 00/0, set REQ_FW=1 with no bus access:
  - BUSY rises 1 cycle after the request;
  - FOURWAY_EN=1 and PAD_MASK=1 on the same edge, 8 CE ticks later;
  - PAD_MASK stays high for exactly 5 CE ticks, then BUSY=0.
- Request TP=01, then a port access at A=1 every 6 cycles -> quiet is never reached; the change is forced at wait_cnt=40; then the normal 5-tick settle.
- Request TP=11 from applied 00 -> applied TEAMPLAYER_EN=01. A REQ_FW=1 together with REQ_TP=10 -> applied TP=00, FW=1.
- Requests and aborts:
  - Request TP=10, then revert to 00 after 3 ticks in WAIT_QUIET -> back to IDLE, outputs unchanged, PAD_MASK never asserted.
  - Change the request during SETTLE -> applied outputs held until SETTLE ends, then a second WAIT_QUIET/SETTLE sequence runs.
- RESET asserted mid-SETTLE with request 01 -> next cycle PAD_MASK=0, BUSY=0, TEAMPLAYER_EN=01.
- Access on A=3 or A=6 during WAIT_QUIET -> quiet_cnt is not cleared, and the change applies at 8 ticks.
